reorder_buffer: RTL and testbench

//  In-order retirement queue of the Tomasulo core. Sits between decoder issue and the register file:

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/rob_operand_resolve.sv | 32 +++
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 tb/tb_reorder_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: tag/index widths, entry layout,
// and the tag <-> index mapping (tag = index + 1, tag 0 means "value ready").
package reorder_buffer_pkg;

    localparam int ROB_ID_WIDTH = 3;
    localparam int REG_WIDTH    = 5;
    localparam int VAL_WIDTH    = 32;
    localparam int REG_SIZE     = 1 << REG_WIDTH;
    localparam int ROB_SIZE     = 1 << ROB_ID_WIDTH;
    localparam int TAG_WIDTH    = ROB_ID_WIDTH + 1;

    typedef logic [ROB_ID_WIDTH-1:0] idx_t;
    typedef logic [TAG_WIDTH-1:0]    tag_t;
    typedef logic [ROB_ID_WIDTH:0]   cnt_t;
    typedef logic [REG_WIDTH-1:0]    reg_t;
    typedef logic [VAL_WIDTH-1:0]    val_t;

    typedef struct packed {
        logic busy;
        logic ready;
        reg_t rd;
        logic is_br;
        val_t pc;
        val_t pred_pc;
        val_t val;
        val_t next_pc;
    } rob_entry_t;

    function automatic idx_t tag_to_idx(input tag_t tag);
        tag_t t;
        t = tag - tag_t'(1);
        return t[ROB_ID_WIDTH-1:0];
    endfunction

    function automatic tag_t idx_to_tag(input idx_t idx);
        return {1'b0, idx} + tag_t'(1);
    endfunction

endpackage

// File: rtl/rob_operand_resolve.sv
// Resolves one source operand: RF value, finished ROB entry, or same-cycle CDB bypass,
// in that priority order; otherwise passes the pending rename tag through.
module rob_operand_resolve
    import reorder_buffer_pkg::*;
(
    input  val_t rf_val,
    input  tag_t rf_lab,
    input  logic entry_ready,
    input  val_t entry_val,
    input  logic cdb_en,
    input  tag_t cdb_tag,
    input  val_t cdb_val,
    output val_t val,
    output tag_t lab
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        val = rf_val;
        lab = rf_lab;
        if (rf_lab == '0) begin
            lab = '0;
        end else if (entry_ready) begin
            val = entry_val;
            lab = '0;
        end else if (cdb_en && cdb_tag == rf_lab) begin
            val = cdb_val;
            lab = '0;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags at issue, captures CDB results,
// resolves operands, commits one entry per cycle and flushes on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    dec2rob_en,
    input  logic [REG_WIDTH-1:0]    dec2rob_rd,
    input  logic                    dec2rob_is_br,
    input  logic [VAL_WIDTH-1:0]    dec2rob_pc,
    input  logic [VAL_WIDTH-1:0]    dec2rob_pred_pc,
    input  logic [VAL_WIDTH-1:0]    rf2rob_val1,
    input  logic [VAL_WIDTH-1:0]    rf2rob_val2,
    input  logic [TAG_WIDTH-1:0]    rf2rob_lab1,
    input  logic [TAG_WIDTH-1:0]    rf2rob_lab2,
    input  logic                    cdb_en,
    input  logic [TAG_WIDTH-1:0]    cdb_tag,
    input  logic [VAL_WIDTH-1:0]    cdb_val,
    input  logic [VAL_WIDTH-1:0]    cdb_next_pc,
    output logic [TAG_WIDTH-1:0]    rob2rf_tag,
    output logic                    rob_full,
    output logic [VAL_WIDTH-1:0]    rob2rs_val1,
    output logic [VAL_WIDTH-1:0]    rob2rs_val2,
    output logic [TAG_WIDTH-1:0]    rob2rs_lab1,
    output logic [TAG_WIDTH-1:0]    rob2rs_lab2,
    output logic                    commit_en,
    output logic [REG_WIDTH-1:0]    rob2rf_commit_rd,
    output logic [VAL_WIDTH-1:0]    rob2rf_commit_res,
    output logic [TAG_WIDTH-1:0]    rob2rf_commit_lab,
    output logic                    flush,
    output logic [VAL_WIDTH-1:0]    redirect_pc
);

    rob_entry_t entries [ROB_SIZE];
    idx_t       head;
    idx_t       tail;
    cnt_t       count;
    logic       pending;
    val_t       pending_pc;

    logic do_issue;
    logic do_commit;
    logic mispredict;
    idx_t cdb_idx;
    idx_t idx1;
    idx_t idx2;

    // Full also covers recovery so the decoder stalls until the flush has landed.
    assign rob_full   = (count == cnt_t'(ROB_SIZE)) || pending || flush;
    assign rob2rf_tag = idx_to_tag(tail);
    assign do_issue   = dec2rob_en && !rob_full && rdy_in;
    assign do_commit  = entries[head].busy && entries[head].ready && !pending && !flush;
    assign mispredict = entries[head].is_br && (entries[head].next_pc != entries[head].pred_pc);
    assign cdb_idx    = tag_to_idx(cdb_tag);
    assign idx1       = tag_to_idx(rf2rob_lab1);
    assign idx2       = tag_to_idx(rf2rob_lab2);

    rob_operand_resolve u_resolve1 (
        .rf_val      (rf2rob_val1),
        .rf_lab      (rf2rob_lab1),
        .entry_ready (entries[idx1].ready),
        .entry_val   (entries[idx1].val),
        .cdb_en      (cdb_en),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .val         (rob2rs_val1),
        .lab         (rob2rs_lab1)
    );

    rob_operand_resolve u_resolve2 (
        .rf_val      (rf2rob_val2),
        .rf_lab      (rf2rob_lab2),
        .entry_ready (entries[idx2].ready),
        .entry_val   (entries[idx2].val),
        .cdb_en      (cdb_en),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .val         (rob2rs_val2),
        .lab         (rob2rs_lab2)
    );

    // NOTE: state updates use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            pending           <= 1'b0;
            pending_pc        <= '0;
            commit_en         <= 1'b0;
            rob2rf_commit_rd  <= '0;
            rob2rf_commit_res <= '0;
            rob2rf_commit_lab <= '0;
            flush             <= 1'b0;
            redirect_pc       <= '0;
            // NOTE: the entry array is a small register file, not a RAM, so it is reset outright.
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (rdy_in) begin
            commit_en <= 1'b0;
            flush     <= 1'b0;
            if (pending) begin
                flush       <= 1'b1;
                redirect_pc <= pending_pc;
                pending     <= 1'b0;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries[i].busy  <= 1'b0;
                    entries[i].ready <= 1'b0;
                end
            end else begin
                if (cdb_en && entries[cdb_idx].busy) begin
                    entries[cdb_idx].val     <= cdb_val;
                    entries[cdb_idx].next_pc <= cdb_next_pc;
                    entries[cdb_idx].ready   <= 1'b1;
                end
                if (do_commit) begin
                    entries[head].busy  <= 1'b0;
                    entries[head].ready <= 1'b0;
                    head                <= head + idx_t'(1);
                    commit_en           <= 1'b1;
                    rob2rf_commit_rd    <= entries[head].rd;
                    rob2rf_commit_res   <= entries[head].val;
                    rob2rf_commit_lab   <= idx_to_tag(head);
                    if (mispredict) begin
                        pending    <= 1'b1;
                        pending_pc <= entries[head].next_pc;
                    end
                end
                if (do_issue) begin
                    entries[tail].busy    <= 1'b1;
                    entries[tail].ready   <= 1'b0;
                    entries[tail].rd      <= dec2rob_rd;
                    entries[tail].is_br   <= dec2rob_is_br;
                    entries[tail].pc      <= dec2rob_pc;
                    entries[tail].pred_pc <= dec2rob_pred_pc;
                    tail                  <= tail + idx_t'(1);
                end
                count <= count + cnt_t'(do_issue) - cnt_t'(do_commit);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: issue/commit, full, ordering,
// operand bypass, mispredict flush and rdy_in stall.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_in, rdy_in;
    logic dec2rob_en, dec2rob_is_br;
    reg_t dec2rob_rd;
    val_t dec2rob_pc, dec2rob_pred_pc;
    val_t rf2rob_val1, rf2rob_val2;
    tag_t rf2rob_lab1, rf2rob_lab2;
    logic cdb_en;
    tag_t cdb_tag;
    val_t cdb_val, cdb_next_pc;
    tag_t rob2rf_tag;
    logic rob_full;
    val_t rob2rs_val1, rob2rs_val2;
    tag_t rob2rs_lab1, rob2rs_lab2;
    logic commit_en;
    reg_t rob2rf_commit_rd;
    val_t rob2rf_commit_res;
    tag_t rob2rf_commit_lab;
    logic flush;
    val_t redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .dec2rob_en        (dec2rob_en),
        .dec2rob_rd        (dec2rob_rd),
        .dec2rob_is_br     (dec2rob_is_br),
        .dec2rob_pc        (dec2rob_pc),
        .dec2rob_pred_pc   (dec2rob_pred_pc),
        .rf2rob_val1       (rf2rob_val1),
        .rf2rob_val2       (rf2rob_val2),
        .rf2rob_lab1       (rf2rob_lab1),
        .rf2rob_lab2       (rf2rob_lab2),
        .cdb_en            (cdb_en),
        .cdb_tag           (cdb_tag),
        .cdb_val           (cdb_val),
        .cdb_next_pc       (cdb_next_pc),
        .rob2rf_tag        (rob2rf_tag),
        .rob_full          (rob_full),
        .rob2rs_val1       (rob2rs_val1),
        .rob2rs_val2       (rob2rs_val2),
        .rob2rs_lab1       (rob2rs_lab1),
        .rob2rs_lab2       (rob2rs_lab2),
        .commit_en         (commit_en),
        .rob2rf_commit_rd  (rob2rf_commit_rd),
        .rob2rf_commit_res (rob2rf_commit_res),
        .rob2rf_commit_lab (rob2rf_commit_lab),
        .flush             (flush),
        .redirect_pc       (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic issue(input reg_t rd, input logic is_br, input val_t pc, input val_t pred);
        dec2rob_en      = 1'b1;
        dec2rob_rd      = rd;
        dec2rob_is_br   = is_br;
        dec2rob_pc      = pc;
        dec2rob_pred_pc = pred;
        tick();
        dec2rob_en      = 1'b0;
    endtask

    task automatic cdb(input tag_t t, input val_t v, input val_t npc);
        cdb_en      = 1'b1;
        cdb_tag     = t;
        cdb_val     = v;
        cdb_next_pc = npc;
        tick();
        cdb_en      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        dec2rob_en = 1'b0; dec2rob_rd = '0; dec2rob_is_br = 1'b0;
        dec2rob_pc = '0; dec2rob_pred_pc = '0;
        rf2rob_val1 = '0; rf2rob_val2 = '0; rf2rob_lab1 = '0; rf2rob_lab2 = '0;
        cdb_en = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_next_pc = '0;

        // Reset state
        do_reset();
        check("rst_commit_en", 32'(commit_en), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_full", 32'(rob_full), 0);
        check("rst_tag", 32'(rob2rf_tag), 1);
        check("rst_res", rob2rf_commit_res, 0);
        check("rst_redirect", redirect_pc, 0);

        // 1: single issue, writeback, commit
        dec2rob_en = 1'b1; dec2rob_rd = 5'd5; dec2rob_is_br = 1'b0;
        #1 check("t1_alloc_tag", 32'(rob2rf_tag), 1);
        tick();
        dec2rob_en = 1'b0;
        cdb(4'd1, 32'h2A, 32'h0);
        check("t1_no_commit_yet", 32'(commit_en), 0);
        tick();
        check("t1_commit_en", 32'(commit_en), 1);
        check("t1_commit_rd", 32'(rob2rf_commit_rd), 5);
        check("t1_commit_res", rob2rf_commit_res, 32'h2A);
        check("t1_commit_lab", 32'(rob2rf_commit_lab), 1);
        tick();
        check("t1_commit_pulse", 32'(commit_en), 0);

        // 2: fill to full, ignored 9th issue, wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dec2rob_en = 1'b1; dec2rob_rd = reg_t'(i + 1); dec2rob_is_br = 1'b0;
            #1 check("t2_alloc_tag", 32'(rob2rf_tag), 32'(i + 1));
            tick();
        end
        check("t2_full", 32'(rob_full), 1);
        check("t2_wrap_tag", 32'(rob2rf_tag), 1);
        dec2rob_rd = 5'd31;
        tick();
        dec2rob_en = 1'b0;
        check("t2_still_full", 32'(rob_full), 1);
        check("t2_tag_unchanged", 32'(rob2rf_tag), 1);
        cdb(4'd1, 32'h11, 32'h0);
        tick();
        check("t2_commit_lab", 32'(rob2rf_commit_lab), 1);
        check("t2_commit_rd", 32'(rob2rf_commit_rd), 1);
        check("t2_not_full", 32'(rob_full), 0);
        check("t2_reuse_tag", 32'(rob2rf_tag), 1);
        issue(5'd9, 1'b0, 32'h0, 32'h0);
        check("t2_full_again", 32'(rob_full), 1);
        cdb(4'd2, 32'h22, 32'h0);
        tick();
        check("t2_second_rd", 32'(rob2rf_commit_rd), 2);
        check("t2_second_lab", 32'(rob2rf_commit_lab), 2);

        // 3: out-of-order writeback, in-order commit
        do_reset();
        issue(5'd3, 1'b0, 32'h0, 32'h0);
        issue(5'd4, 1'b0, 32'h0, 32'h0);
        cdb(4'd2, 32'hB, 32'h0);
        check("t3_no_commit_b", 32'(commit_en), 0);
        cdb(4'd1, 32'hA, 32'h0);
        check("t3_no_commit_same", 32'(commit_en), 0);
        tick();
        check("t3_a_en", 32'(commit_en), 1);
        check("t3_a_lab", 32'(rob2rf_commit_lab), 1);
        check("t3_a_res", rob2rf_commit_res, 32'hA);
        tick();
        check("t3_b_en", 32'(commit_en), 1);
        check("t3_b_lab", 32'(rob2rf_commit_lab), 2);
        check("t3_b_rd", 32'(rob2rf_commit_rd), 4);
        tick();
        check("t3_idle", 32'(commit_en), 0);

        // 4: operand resolution
        do_reset();
        for (int i = 0; i < 4; i++) issue(reg_t'(i + 10), 1'b0, 32'h0, 32'h0);
        cdb(4'd3, 32'h7, 32'h0);
        rf2rob_lab1 = 4'd3; rf2rob_val1 = 32'hDEAD;
        rf2rob_lab2 = 4'd4; rf2rob_val2 = 32'h55;
        cdb_en = 1'b1; cdb_tag = 4'd4; cdb_val = 32'h9;
        #1;
        check("t4_entry_val", rob2rs_val1, 32'h7);
        check("t4_entry_lab", 32'(rob2rs_lab1), 0);
        check("t4_cdb_val", rob2rs_val2, 32'h9);
        check("t4_cdb_lab", 32'(rob2rs_lab2), 0);
        rf2rob_lab1 = 4'd0; rf2rob_val1 = 32'h123;
        rf2rob_lab2 = 4'd2; rf2rob_val2 = 32'h77;
        #1;
        check("t4_rf_val", rob2rs_val1, 32'h123);
        check("t4_rf_lab", 32'(rob2rs_lab1), 0);
        check("t4_wait_lab", 32'(rob2rs_lab2), 2);
        cdb_en = 1'b0;
        rf2rob_lab1 = '0; rf2rob_lab2 = '0;

        // 5: mispredicted branch
        do_reset();
        issue(5'd1, 1'b1, 32'h100, 32'h104);
        issue(5'd7, 1'b0, 32'h104, 32'h108);
        cdb(4'd1, 32'h104, 32'h200);
        check("t5_pre_commit", 32'(commit_en), 0);
        tick();
        check("t5_commit_en", 32'(commit_en), 1);
        check("t5_commit_res", rob2rf_commit_res, 32'h104);
        check("t5_no_flush_yet", 32'(flush), 0);
        check("t5_full_pending", 32'(rob_full), 1);
        tick();
        check("t5_flush", 32'(flush), 1);
        check("t5_commit_drop", 32'(commit_en), 0);
        check("t5_redirect", redirect_pc, 32'h200);
        check("t5_full_flush", 32'(rob_full), 1);
        tick();
        check("t5_flush_pulse", 32'(flush), 0);
        check("t5_full_after", 32'(rob_full), 0);
        check("t5_tag_after", 32'(rob2rf_tag), 1);

        // 6: rdy_in stall with head ready
        do_reset();
        issue(5'd6, 1'b0, 32'h0, 32'h0);
        cdb(4'd1, 32'h66, 32'h0);
        rdy_in = 1'b0;
        dec2rob_en = 1'b1; dec2rob_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stall_commit", 32'(commit_en), 0);
            check("t6_stall_tag", 32'(rob2rf_tag), 2);
        end
        rdy_in = 1'b1;
        dec2rob_en = 1'b0;
        tick();
        check("t6_resume_en", 32'(commit_en), 1);
        check("t6_resume_res", rob2rf_commit_res, 32'h66);
        check("t6_resume_lab", 32'(rob2rf_commit_lab), 1);
        check("t6_resume_tag", 32'(rob2rf_tag), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
